// File: rtl/compare_arbiter_if.sv
// Request/operand bus and result bus between the requesters and compare_arbiter.
// The master side drives requests and operands; the slave side returns grant and result.
interface compare_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [3:0]         req;
  logic [4*WIDTH-1:0] a_in;
  logic [4*WIDTH-1:0] b_in;
  logic [3:0]         gnt;
  logic               busy;
  logic               done;
  logic [1:0]         done_id;
  logic               less;
  logic               equal;
  logic               greater;

  modport master (
    output req, a_in, b_in,
    input  gnt, busy, done, done_id, less, equal, greater
  );

  modport slave (
    input  req, a_in, b_in,
    output gnt, busy, done, done_id, less, equal, greater
  );
endinterface

// File: rtl/compare_arbiter.sv
// One registered unsigned comparator shared by four requesters under round-robin
// arbitration; each comparison runs IDLE -> CMP -> DONE with fixed latency.
module compare_arbiter #(
  parameter int WIDTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  compare_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CMP  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  logic [1:0]       state_r;
  logic [3:0]       gnt_r;
  logic             busy_r;
  logic             done_r;
  logic [1:0]       done_id_r;
  logic             less_r;
  logic             equal_r;
  logic             greater_r;
  logic [1:0]       last_r;
  logic [1:0]       win_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;

  logic [1:0]       win_s;
  logic             found_s;
  logic [1:0]       cand_s;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Round-robin pick: scan upward from the requester after the last winner.
  always_comb begin
    win_s   = 2'd0;
    found_s = 1'b0;
    cand_s  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cand_s = last_r + 2'd1 + i[1:0];
      if (!found_s && bus.req[cand_s]) begin
        found_s = 1'b1;
        win_s   = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Sequencer: grant and operand capture, comparison, result pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      gnt_r     <= 4'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      done_id_r <= 2'd0;
      less_r    <= 1'b0;
      equal_r   <= 1'b0;
      greater_r <= 1'b0;
      last_r    <= 2'd3;
      win_r     <= 2'd0;
      a_r       <= '0;
      b_r       <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|bus.req) begin
            a_r     <= bus.a_in[win_s*WIDTH +: WIDTH];
            b_r     <= bus.b_in[win_s*WIDTH +: WIDTH];
            gnt_r   <= onehot4(win_s);
            win_r   <= win_s;
            last_r  <= win_s;
            busy_r  <= 1'b1;
            state_r <= ST_CMP;
          end else begin
            gnt_r   <= 4'd0;
          end
        end
        ST_CMP: begin
          // Flags come from the latched operands only; bus changes are ignored.
          gnt_r     <= 4'd0;
          less_r    <= (a_r < b_r);
          equal_r   <= (a_r == b_r);
          greater_r <= (a_r > b_r);
          done_r    <= 1'b1;
          done_id_r <= win_r;
          state_r   <= ST_DONE;
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          gnt_r   <= 4'd0;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.done_id = done_id_r;
  assign bus.less    = less_r;
  assign bus.equal   = equal_r;
  assign bus.greater = greater_r;

endmodule

// File: tb/tb_compare_arbiter.sv
// Bench for compare_arbiter: a transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_compare_arbiter;
  localparam int W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  compare_arbiter_if #(.WIDTH(W)) ifc();
  compare_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // Model state: phase -1 free, 0 = the cycle after a grant, 1 = result cycle.
  logic [3:0] m_gnt;
  logic       m_busy, m_done, m_less, m_equal, m_greater;
  logic [1:0] m_id;
  int         m_last, m_w, m_a, m_b, phase;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_gnt = 4'd0; m_busy = 1'b0; m_done = 1'b0; m_id = 2'd0;
    m_less = 1'b0; m_equal = 1'b0; m_greater = 1'b0;
    m_last = 3; m_w = 0; m_a = 0; m_b = 0; phase = -1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else if (phase < 0) begin
        if (ifc.req != 4'd0) begin
          m_w = -1;
          for (int k = 1; k <= 4; k++) begin
            if (m_w < 0 && ifc.req[(m_last + k) % 4]) m_w = (m_last + k) % 4;
          end
          m_a    = int'((ifc.a_in >> (m_w * W)) & 16'hF);
          m_b    = int'((ifc.b_in >> (m_w * W)) & 16'hF);
          m_gnt  = 4'(1 << m_w);
          m_last = m_w;
          m_busy = 1'b1;
          phase  = 0;
        end else begin
          m_gnt = 4'd0;
        end
      end else if (phase == 0) begin
        m_gnt     = 4'd0;
        m_done    = 1'b1;
        m_id      = 2'(m_w);
        m_less    = (m_a < m_b);
        m_equal   = (m_a == m_b);
        m_greater = (m_a > m_b);
        phase     = 1;
      end else begin
        m_done = 1'b0;
        m_busy = 1'b0;
        phase  = -1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("cyc_gnt", 32'(ifc.gnt), 32'(m_gnt));
        chk("cyc_busy", 32'(ifc.busy), 32'(m_busy));
        chk("cyc_done", 32'(ifc.done), 32'(m_done));
        chk("cyc_done_id", 32'(ifc.done_id), 32'(m_id));
        chk("cyc_flags", 32'({ifc.less, ifc.equal, ifc.greater}),
            32'({m_less, m_equal, m_greater}));
      end
    end
  end

  task automatic set_ops(input int i, input logic [3:0] a, input logic [3:0] b);
    ifc.a_in[i*W +: W] = a;
    ifc.b_in[i*W +: W] = b;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    ifc.req  = 4'd0;
    ifc.a_in = '0;
    ifc.b_in = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_gnt(output logic [3:0] g);
    bit ok = 1'b0;
    g = 4'd0;
    for (int n = 0; n < 12 && !ok; n++) begin
      @(posedge clk); #1;
      if (ifc.gnt != 4'd0) begin ok = 1'b1; g = ifc.gnt; end
    end
    chk("gnt_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_done(output logic [1:0] id, output logic [2:0] f);
    bit ok = 1'b0;
    id = 2'd0; f = 3'd0;
    for (int n = 0; n < 12 && !ok; n++) begin
      @(posedge clk); #1;
      if (ifc.done) begin
        ok = 1'b1; id = ifc.done_id; f = {ifc.less, ifc.equal, ifc.greater};
      end
    end
    chk("done_seen", 32'(ok), 32'd1);
  endtask

  function automatic logic [3:0] rand_op();
    int r = $urandom_range(0, 3);
    if (r == 0) return 4'd0;
    if (r == 1) return 4'd15;
    return 4'($urandom_range(0, 15));
  endfunction

  logic [3:0] g;
  logic [1:0] id;
  logic [2:0] f;
  int rr_exp[5]   = '{0, 1, 2, 3, 0};
  int ext_id[3]   = '{0, 1, 3};
  logic [2:0] ext_f[3] = '{3'b001, 3'b010, 3'b100};

  initial begin
    ifc.req = 4'd0; ifc.a_in = '0; ifc.b_in = '0;
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    chk("rst_outputs", 32'({ifc.gnt, ifc.busy, ifc.done, ifc.done_id,
                            ifc.less, ifc.equal, ifc.greater}), 32'd0);
    @(posedge clk); #1;
    do_reset();

    // Single request from requester 2.
    set_ops(2, 4'd5, 4'd9);
    ifc.req = 4'b0100;
    @(posedge clk); #1;
    chk("single_gnt", 32'(ifc.gnt), 32'h4);
    chk("single_busy", 32'(ifc.busy), 32'd1);
    ifc.req = 4'd0;
    @(posedge clk); #1;
    chk("single_done", 32'(ifc.done), 32'd1);
    chk("single_id", 32'(ifc.done_id), 32'd2);
    chk("single_flags", 32'({ifc.less, ifc.equal, ifc.greater}), 32'b100);

    // All four requesting continuously.
    do_reset();
    for (int i = 0; i < 4; i++) set_ops(i, 4'(i), 4'(3 - i));
    ifc.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_gnt(g);
      chk("rr_gnt", 32'(g), 32'(1 << rr_exp[n]));
      @(posedge clk); #1;
      chk("rr_done_id", 32'(ifc.done_id), 32'(rr_exp[n]));
    end
    ifc.req = 4'd0;

    // Operand extremes.
    do_reset();
    set_ops(0, 4'd15, 4'd0);
    set_ops(1, 4'd0, 4'd0);
    set_ops(3, 4'd0, 4'd15);
    ifc.req = 4'b1011;
    for (int n = 0; n < 3; n++) begin
      wait_gnt(g);
      ifc.req = ifc.req & ~g;
      wait_done(id, f);
      chk("ext_id", 32'(id), 32'(ext_id[n]));
      chk("ext_flags", 32'(f), 32'(ext_f[n]));
    end

    // Operand change while busy is ignored.
    do_reset();
    set_ops(0, 4'd3, 4'd3);
    ifc.req = 4'b0001;
    wait_gnt(g);
    ifc.req = 4'd0;
    set_ops(0, 4'd7, 4'd3);
    wait_done(id, f);
    chk("busychg_flags", 32'(f), 32'b010);

    // Reset during CMP aborts, then requester 0 side has priority again.
    do_reset();
    set_ops(0, 4'd1, 4'd2);
    ifc.req = 4'b0001;
    wait_gnt(g);
    ifc.req = 4'd0;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", 32'({ifc.gnt, ifc.busy, ifc.done, ifc.done_id,
                              ifc.less, ifc.equal, ifc.greater}), 32'd0);
    ifc.req = 4'b1010;
    set_ops(1, 4'd4, 4'd4);
    set_ops(3, 4'd9, 4'd1);
    for (int n = 0; n < 2; n++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 32'(ifc.done), 32'd0);
    end
    rst_n = 1'b1;
    wait_gnt(g);
    chk("abort_first_gnt", 32'(g), 32'b0010);
    ifc.req = 4'b1000;
    wait_done(id, f);

    // Flags hold while idle.
    do_reset();
    set_ops(1, 4'd2, 4'd9);
    ifc.req = 4'b0010;
    wait_gnt(g);
    ifc.req = 4'd0;
    wait_done(id, f);
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      chk("hold_state", 32'({ifc.less, ifc.done, ifc.busy}), 32'b100);
    end

    // Randomized traffic obeying the request handshake.
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 300) rst_n = 1'b0;
      if (cyc == 302) rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (ifc.gnt[i]) begin
          if ($urandom_range(0, 3) == 0) set_ops(i, rand_op(), rand_op());
          else ifc.req[i] = 1'b0;
        end else if (!ifc.req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            set_ops(i, rand_op(), rand_op());
            ifc.req[i] = 1'b1;
          end else if (ifc.busy) begin
            set_ops(i, rand_op(), rand_op());
          end
        end
      end
    end
    ifc.req = 4'd0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
